// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its lane aligner.
package mem_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned BE_W     = DATA_W / 8;

    // RV32I load/store width and sign codes
    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Request as captured at the accepting edge
    typedef struct packed {
        logic                write;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [FUNCT3_W-1:0] funct3;
    } mem_req_t;

    // True for the five width codes the responder understands
    function automatic logic funct3_legal(input logic [FUNCT3_W-1:0] f3);
        logic legal;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load lane select/extend, store merge, error flag.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [1:0]          lane,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rword,
    output logic [DATA_W-1:0]   load_data_c,
    output logic [DATA_W-1:0]   store_word_c,
    output logic                err_c
);

    logic                misaligned;
    logic [7:0]          sel_byte;
    logic [15:0]         sel_half;
    logic [BE_W-1:0]     byte_en;
    logic [DATA_W-1:0]   store_lanes;

    // Misalignment and illegal width code
    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = lane[0];
            F3_W:        misaligned = (lane != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        err_c = misaligned || !funct3_legal(funct3);
    end

    // Pick the addressed byte and halfword out of the stored word
    always_comb begin
        sel_byte = rword[7:0];
        case (lane)
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            2'd3:    sel_byte = rword[31:24];
            default: sel_byte = rword[7:0];
        endcase
        sel_half = lane[1] ? rword[31:16] : rword[15:0];
    end

    // Load result: right-aligned, sign or zero extended, zero on error
    always_comb begin
        load_data_c = '0;
        case (funct3)
            F3_B:    load_data_c = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
            F3_H:    load_data_c = {{(DATA_W-16){sel_half[15]}}, sel_half};
            F3_W:    load_data_c = rword;
            F3_BU:   load_data_c = {{(DATA_W-8){1'b0}}, sel_byte};
            F3_HU:   load_data_c = {{(DATA_W-16){1'b0}}, sel_half};
            default: load_data_c = '0;
        endcase
        if (err_c) begin
            load_data_c = '0;
        end
    end

    // Store byte enables with the source replicated into every lane
    always_comb begin
        byte_en     = '0;
        store_lanes = '0;
        case (funct3)
            F3_B: begin
                byte_en     = BE_W'(1) << lane;
                store_lanes = {BE_W{wdata[7:0]}};
            end
            F3_H: begin
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                store_lanes = {(BE_W/2){wdata[15:0]}};
            end
            F3_W: begin
                byte_en     = '1;
                store_lanes = wdata;
            end
            default: begin
                byte_en     = '0;
                store_lanes = '0;
            end
        endcase
        if (err_c) begin
            byte_en = '0;
        end
    end

    // Merge enabled lanes over the old word; untouched lanes keep their value
    always_comb begin
        store_word_c = rword;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (byte_en[i]) begin
                store_word_c[8*i +: 8] = store_lanes[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with configurable access latency.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [FUNCT3_W-1:0] req_funct3,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam state_e ST_AFTER_ACCEPT = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;

    state_e            state;
    state_e            state_next;
    logic              accept;
    logic              do_access;
    logic              resp_done;
    mem_req_t          req_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] mem_rword;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] store_word_c;
    logic              align_err_c;
    logic              unused_addr_hi;

    assign word_idx       = req_q.addr[IDX_W+1:2];
    assign mem_rword      = mem_q[word_idx];
    assign unused_addr_hi = ^req_q.addr[ADDR_W-1:IDX_W+2];

    mem_lane_align u_align (
        .funct3       (req_q.funct3),
        .lane         (req_q.addr[1:0]),
        .wdata        (req_q.wdata),
        .rword        (mem_rword),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c),
        .err_c        (align_err_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_access  = 1'b0;
        resp_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = ST_AFTER_ACCEPT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                do_access  = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_done  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, latency counter and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q      <= '0;
            wait_cnt   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            req_ready  <= (state_next == ST_IDLE);
            resp_valid <= (state_next == ST_RESP);
            if (accept) begin
                req_q    <= '{write: req_write, addr: req_addr,
                              wdata: req_wdata, funct3: req_funct3};
                wait_cnt <= CNT_LOAD;
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (do_access) begin
                resp_err   <= align_err_c;
                resp_rdata <= req_q.write ? '0 : load_data_c;
            end else if (resp_done) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Backing array: written only on the closing edge of a clean store access
    always_ff @(posedge clk) begin
        if (do_access && req_q.write && !align_err_c) begin
            mem_q[word_idx] <= store_word_c;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (one wait cycle / zero wait cycles)
// checked every cycle against a transaction-level memory model.
module tb_mem_responder;

    localparam int unsigned NDUT   = 2;
    localparam int unsigned WAIT0  = 1;
    localparam int unsigned WAIT1  = 0;
    localparam int unsigned DEPTH0 = 1024;
    localparam int unsigned DEPTH1 = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [NDUT-1:0]       req_valid;
    logic [NDUT-1:0]       req_ready;
    logic [NDUT-1:0]       req_write;
    logic [NDUT-1:0][31:0] req_addr;
    logic [NDUT-1:0][31:0] req_wdata;
    logic [NDUT-1:0][2:0]  req_funct3;
    logic [NDUT-1:0]       resp_valid;
    logic [NDUT-1:0]       resp_ready;
    logic [NDUT-1:0][31:0] resp_rdata;
    logic [NDUT-1:0]       resp_err;

    mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(WAIT0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH1), .WAIT_CYCLES(WAIT1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h at t=%0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? int'(WAIT0) : int'(WAIT1);
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? int'(DEPTH0) : int'(DEPTH1);
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic m_err(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a[0];
            3'd2:       return (a != 2'd0);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b > 32'd127)   ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h > 32'd32767) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] m;
        logic [31:0] v;
        case (f3)
            3'd0: begin
                m = 32'hFF << (8 * int'(a));
                v = (wd & 32'hFF) << (8 * int'(a));
            end
            3'd1: begin
                m = 32'hFFFF << (16 * int'(a[1]));
                v = (wd & 32'hFFFF) << (16 * int'(a[1]));
            end
            default: begin
                m = 32'hFFFF_FFFF;
                v = wd;
            end
        endcase
        return (w & ~m) | v;
    endfunction

    logic [31:0] mm [NDUT][DEPTH0];
    bit   [NDUT-1:0] pend = '0;
    int          edges [NDUT];
    logic        c_wr  [NDUT];
    logic [31:0] c_addr[NDUT];
    logic [31:0] c_wd  [NDUT];
    logic [2:0]  c_f3  [NDUT];
    logic [31:0] e_rd  [NDUT];
    logic        e_er  [NDUT];

    // Work out the response (and apply a store) once the access has completed
    task automatic model_resolve(input int d);
        int unsigned idx;
        idx = (c_addr[d] >> 2) % depth_of(d);
        e_rd[d] = 32'h0;
        e_er[d] = m_err(c_f3[d], c_addr[d][1:0]);
        if (!e_er[d]) begin
            if (c_wr[d]) mm[d][idx] = m_store(mm[d][idx], c_wd[d], c_f3[d], c_addr[d][1:0]);
            else         e_rd[d] = m_load(mm[d][idx], c_f3[d], c_addr[d][1:0]);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int d = 0; d < int'(NDUT); d++) begin
            if (!reset) begin
                pend[d] = 1'b0;
                check(d, "reset_resp_valid", 32'(resp_valid[d]), 32'd0);
                check(d, "reset_resp_rdata", resp_rdata[d], 32'd0);
                check(d, "reset_resp_err", 32'(resp_err[d]), 32'd0);
            end else if (pend[d]) begin
                bit expv;
                edges[d]++;
                if (edges[d] == wait_of(d) + 1) model_resolve(d);
                expv = (edges[d] >= wait_of(d) + 1);
                check(d, "busy_req_ready", 32'(req_ready[d]), 32'd0);
                check(d, "resp_valid", 32'(resp_valid[d]), 32'(expv));
                if (expv) begin
                    check(d, "resp_rdata", resp_rdata[d], e_rd[d]);
                    check(d, "resp_err", 32'(resp_err[d]), 32'(e_er[d]));
                    if (resp_ready[d]) pend[d] = 1'b0;
                end
            end else begin
                check(d, "idle_req_ready", 32'(req_ready[d]), 32'd1);
                check(d, "idle_resp_valid", 32'(resp_valid[d]), 32'd0);
                if (req_valid[d]) begin
                    c_wr[d]   = req_write[d];
                    c_addr[d] = req_addr[d];
                    c_wd[d]   = req_wdata[d];
                    c_f3[d]   = req_funct3[d];
                    pend[d]   = 1'b1;
                    edges[d]  = -1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Present a request; returns at the accepting edge + 1, then scrambles the inputs
    task automatic issue(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, output bit ok);
        int n = 0;
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        req_funct3[d] = f3;
        @(negedge clk);
        while (!req_ready[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        ok = req_ready[d];
        if (!ok) check(d, "accept_timeout", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        req_write[d]  = 1'($urandom);
        req_addr[d]   = $urandom;
        req_wdata[d]  = $urandom;
        req_funct3[d] = 3'($urandom);
    endtask

    task automatic xact(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        bit ok;
        int n = 0;
        rd  = 32'h0;
        er  = 1'b0;
        lat = -1;
        issue(d, wr, addr, wd, f3, ok);
        if (!ok) return;
        @(negedge clk);
        while (!resp_valid[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!resp_valid[d]) begin
            check(d, "resp_timeout", 32'(resp_valid[d]), 32'd1);
            return;
        end
        lat = n;
        @(posedge clk);
        #1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        resp_ready[d] = 1'b1;
        @(negedge clk);
        rd = resp_rdata[d];
        er = resp_err[d];
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;

        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        resp_ready = '0;

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < int'(NDUT); d++) begin
            check(d, "post_reset_req_ready", 32'(req_ready[d]), 32'd1);
            check(d, "post_reset_resp_valid", 32'(resp_valid[d]), 32'd0);
            check(d, "post_reset_resp_rdata", resp_rdata[d], 32'd0);
            check(d, "post_reset_resp_err", 32'(resp_err[d]), 32'd0);
        end
        @(posedge clk);
        #1;

        // SW then LW, latency two edges after accept
        xact(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 0, rd, er, lat);
        check(0, "sw_latency", 32'(lat), 32'd2);
        check(0, "sw_rdata_zero", rd, 32'd0);
        xact(0, 1'b0, 32'h100, 32'h0, 3'b010, 0, rd, er, lat);
        check(0, "lw_latency", 32'(lat), 32'd2);
        check(0, "lw_0x100", rd, 32'hDEAD_BEEF);

        // Byte / halfword extension
        xact(0, 1'b1, 32'h200, 32'h80FF_7F01, 3'b010, 0, rd, er, lat);
        xact(0, 1'b0, 32'h203, 32'h0, 3'b000, 0, rd, er, lat);
        check(0, "lb_0x203", rd, 32'hFFFF_FF80);
        xact(0, 1'b0, 32'h203, 32'h0, 3'b100, 0, rd, er, lat);
        check(0, "lbu_0x203", rd, 32'h0000_0080);
        xact(0, 1'b0, 32'h200, 32'h0, 3'b001, 1, rd, er, lat);
        check(0, "lh_0x200", rd, 32'h0000_7F01);
        xact(0, 1'b0, 32'h202, 32'h0, 3'b101, 0, rd, er, lat);
        check(0, "lhu_0x202", rd, 32'h0000_80FF);

        // Partial stores preserve the other lanes
        xact(0, 1'b1, 32'h300, 32'h1122_3344, 3'b010, 0, rd, er, lat);
        xact(0, 1'b1, 32'h301, 32'h0000_00AA, 3'b000, 0, rd, er, lat);
        xact(0, 1'b1, 32'h302, 32'h0000_BEEF, 3'b001, 0, rd, er, lat);
        xact(0, 1'b0, 32'h300, 32'h0, 3'b010, 0, rd, er, lat);
        check(0, "merge_0x300", rd, 32'hBEEF_AA44);

        // Misaligned requests
        xact(0, 1'b0, 32'h102, 32'h0, 3'b010, 0, rd, er, lat);
        check(0, "lw_mis_err", 32'(er), 32'd1);
        check(0, "lw_mis_rdata", rd, 32'd0);
        xact(0, 1'b1, 32'h101, 32'h0000_FFFF, 3'b001, 0, rd, er, lat);
        check(0, "sh_mis_err", 32'(er), 32'd1);
        check(0, "sh_mis_latency", 32'(lat), 32'd2);
        xact(0, 1'b0, 32'h100, 32'h0, 3'b010, 0, rd, er, lat);
        check(0, "lw_0x100_unchanged", rd, 32'hDEAD_BEEF);

        // Back-pressure: response held while resp_ready stays low
        xact(0, 1'b0, 32'h300, 32'h0, 3'b010, 5, rd, er, lat);
        check(0, "stall_rdata", rd, 32'hBEEF_AA44);

        // Zero-wait instance: one-edge latency and address wrap-around
        xact(1, 1'b1, 32'h104, 32'hCAFE_F00D, 3'b010, 0, rd, er, lat);
        check(1, "w0_sw_latency", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h004, 32'h0, 3'b010, 0, rd, er, lat);
        check(1, "w0_lw_latency", 32'(lat), 32'd1);
        check(1, "w0_wrap_lw", rd, 32'hCAFE_F00D);

        // Reset during WAIT aborts the store
        xact(0, 1'b1, 32'h400, 32'h0, 3'b010, 0, rd, er, lat);
        issue(0, 1'b1, 32'h400, 32'h1234_5678, 3'b010, ok);
        #1 reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check(0, "abort_req_ready", 32'(req_ready[0]), 32'd1);
        check(0, "abort_resp_valid", 32'(resp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        xact(0, 1'b0, 32'h400, 32'h0, 3'b010, 0, rd, er, lat);
        check(0, "abort_lw_0x400", rd, 32'd0);

        // Randomised traffic over a preloaded 16-word window with aliased upper bits
        for (int d = 0; d < int'(NDUT); d++) begin
            for (int w = 0; w < 16; w++) begin
                xact(d, 1'b1, 32'(w * 4), $urandom, 3'b010, 0, rd, er, lat);
            end
        end
        repeat (300) begin
            int          d;
            int          sh;
            int          k;
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] addr;
            d  = $urandom_range(0, 1);
            sh = (d == 0) ? 12 : 8;
            wr = 1'($urandom_range(0, 1));
            if (wr) begin
                k  = $urandom_range(0, 5);
                f3 = (k < 4) ? 3'(k) : 3'(k + 2);
            end else begin
                f3 = 3'($urandom);
            end
            addr = ($urandom << sh) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            xact(d, wr, addr, $urandom, f3, $urandom_range(0, 3), rd, er, lat);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
